// File: rtl/ldm_seq.sv
// rtl/ldm_seq.sv - load/store-multiple sequencer (optional writeback via LDM_WB_EN)
module ldm_seq #(
  parameter  int NREGS = 16,
  parameter  int AW    = 32,
  localparam int IDXW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NREGS-1:0] list,
  input  logic [AW-1:0]    base,
  input  logic             up,
  input  logic             pre,
  input  logic             advance,
  output logic             busy,
  output logic             valid,
  output logic [IDXW-1:0]  idx,
  output logic [AW-1:0]    addr,
  output logic             last,
  output logic             done
`ifdef LDM_WB_EN
  ,
  output logic [AW-1:0]    wb_addr
`endif
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [NREGS-1:0] r_list;
  logic [AW-1:0]    r_addr;
  logic             r_done;

  logic [IDXW:0]    w_cnt;
  logic [AW-1:0]    w_four_cnt;
  logic [AW-1:0]    w_lo_addr;
  logic [NREGS-1:0] w_list_rest;
  logic             w_one_left;
  logic             w_accept;
  logic             w_step;

  function automatic logic [IDXW:0] f_popcount(input logic [NREGS-1:0] l);
    logic [IDXW:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++) c = c + (IDXW+1)'(l[i]);
    return c;
  endfunction

  // Scan from the top so the last hit is the lowest set bit.
  function automatic logic [IDXW-1:0] f_lowest(input logic [NREGS-1:0] l);
    logic [IDXW-1:0] r;
    r = '0;
    for (int i = NREGS - 1; i >= 0; i--) if (l[i]) r = IDXW'(i);
    return r;
  endfunction

  assign w_cnt       = f_popcount(list);
  assign w_four_cnt  = AW'(w_cnt) << 2;
  // Clearing the lowest set bit retires the current transfer.
  assign w_list_rest = r_list & (r_list - NREGS'(1));
  assign w_one_left  = (r_list != '0) && (w_list_rest == '0);
  assign w_accept    = (r_state == S_IDLE) && start;
  assign w_step      = (r_state == S_RUN) && advance;

  // Lowest word address of the block; transfers always walk upward from here.
  always_comb begin
    w_lo_addr = base;
    case ({up, pre})
      2'b10:   w_lo_addr = base;
      2'b11:   w_lo_addr = base + AW'(4);
      2'b00:   w_lo_addr = base - w_four_cnt + AW'(4);
      default: w_lo_addr = base - w_four_cnt;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and transfer-status outputs.
  always_comb begin
    w_next_state = r_state;
    busy         = 1'b0;
    valid        = 1'b0;
    last         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (list != '0)) w_next_state = S_RUN;
      end
      S_RUN: begin
        busy  = 1'b1;
        valid = 1'b1;
        last  = w_one_left;
        if (advance && w_one_left) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Remaining list, current address and the completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_list <= '0;
      r_addr <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= (w_accept && (list == '0)) || (w_step && w_one_left);
      if (w_accept) begin
        r_list <= list;
        r_addr <= w_lo_addr;
      end else if (w_step) begin
        r_list <= w_list_rest;
        r_addr <= r_addr + AW'(4);
      end
    end
  end

`ifdef LDM_WB_EN
  logic [AW-1:0] r_wb_addr;

  // Final Rn value captured at start, so it is stable by the time done pulses.
  always_ff @(posedge clk) begin
    if (reset)         r_wb_addr <= '0;
    else if (w_accept) r_wb_addr <= up ? (base + w_four_cnt) : (base - w_four_cnt);
  end

  assign wb_addr = r_wb_addr;
`endif

  assign idx  = f_lowest(r_list);
  assign addr = r_addr;
  assign done = r_done;

endmodule

// File: tb/tb_ldm_seq.sv
// tb/tb_ldm_seq.sv - self-checking bench for ldm_seq
module tb_ldm_seq;
  localparam int NREGS = 16;
  localparam int AW    = 32;
  localparam int IDXW  = 4;

  logic             clk = 1'b0;
  logic             reset, start, up, pre, advance;
  logic [NREGS-1:0] list;
  logic [AW-1:0]    base;
  logic             busy, valid, last, done;
  logic [IDXW-1:0]  idx;
  logic [AW-1:0]    addr;
`ifdef LDM_WB_EN
  logic [AW-1:0]    wb_addr;
`endif

  ldm_seq #(.NREGS(NREGS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .list(list), .base(base),
    .up(up), .pre(pre), .advance(advance), .busy(busy), .valid(valid),
    .idx(idx), .addr(addr), .last(last), .done(done)
`ifdef LDM_WB_EN
    , .wb_addr(wb_addr)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of the transfers still owed, built from the list at start.
  typedef struct {
    logic [IDXW-1:0] idx;
    logic [AW-1:0]   addr;
  } xfer_t;

  xfer_t       m_q[$];
  logic        m_done = 1'b0;
  logic [AW-1:0] m_wb = '0;

  typedef struct {
    string           name;
    logic            up;
    logic            pre;
    logic [NREGS-1:0] list;
    logic [AW-1:0]   base;
    int              n;
    logic [IDXW-1:0] f_idx;
    logic [AW-1:0]   f_addr;
    logic [IDXW-1:0] l_idx;
    logic [AW-1:0]   l_addr;
    logic [AW-1:0]   wb;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int            cnt;
    logic [AW-1:0] lo;
    int            k;
    if (reset) begin
      m_q.delete();
      m_done = 1'b0;
      m_wb   = '0;
    end else begin
      m_done = 1'b0;
      if (m_q.size() == 0) begin
        if (start) begin
          cnt = $countones(list);
          if (up) lo = pre ? base + 4 : base;
          else    lo = pre ? base - 32'(4 * cnt) : base - 32'(4 * cnt) + 4;
          m_wb = up ? base + 32'(4 * cnt) : base - 32'(4 * cnt);
          if (cnt == 0) m_done = 1'b1;
          k = 0;
          for (int i = 0; i < NREGS; i++) begin
            if (list[i]) begin
              m_q.push_back('{IDXW'(i), lo + 32'(4 * k)});
              k++;
            end
          end
        end
      end else if (advance) begin
        m_q.delete(0);
        if (m_q.size() == 0) m_done = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic act_busy;
    act_busy = (m_q.size() != 0);
    chk("busy", busy, act_busy);
    chk("valid", valid, act_busy);
    chk("done", done, m_done);
    if (act_busy) begin
      chk("idx", idx, m_q[0].idx);
      chk("addr", addr, m_q[0].addr);
      chk("last", last, m_q.size() == 1);
    end else begin
      chk("idle_idx", idx, 0);
      chk("idle_last", last, 0);
    end
`ifdef LDM_WB_EN
    chk("wb_addr", wb_addr, m_wb);
`endif
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic run_vec(input vec_t v);
    int n, guard;
    logic [IDXW-1:0] fi, li;
    logic [AW-1:0]   fa, la;
    start = 1'b1; up = v.up; pre = v.pre; list = v.list; base = v.base; advance = 1'b1;
    cycle();
    start = 1'b0; list = $urandom; base = $urandom;
    n = 0; guard = 0;
    fi = '0; li = '0; fa = '0; la = '0;
    if (v.n == 0) chk({v.name, "_zero_done"}, done, 1);
    while (busy && guard < 40) begin
      if (n == 0) begin fi = idx; fa = addr; end
      li = idx; la = addr;
      n++;
      cycle();
      guard++;
    end
    chk({v.name, "_timeout"}, guard < 40, 1);
    chk({v.name, "_count"}, n, v.n);
    if (v.n > 0) begin
      chk({v.name, "_first_idx"}, fi, v.f_idx);
      chk({v.name, "_first_addr"}, fa, v.f_addr);
      chk({v.name, "_last_idx"}, li, v.l_idx);
      chk({v.name, "_last_addr"}, la, v.l_addr);
      chk({v.name, "_done"}, done, 1);
    end
`ifdef LDM_WB_EN
    chk({v.name, "_wb"}, wb_addr, v.wb);
`endif
    cycle();
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{"ia",  1'b1, 1'b0, 16'h0085, 32'h100,        3,  4'd0,  32'h100,        4'd7,  32'h108, 32'h10C};
    tbl[1] = '{"db",  1'b0, 1'b1, 16'h8003, 32'h200,        3,  4'd0,  32'h1F4,        4'd15, 32'h1FC, 32'h1F4};
    tbl[2] = '{"nil", 1'b1, 1'b0, 16'h0000, 32'h300,        0,  4'd0,  32'h0,          4'd0,  32'h0,   32'h300};
    tbl[3] = '{"da",  1'b0, 1'b0, 16'hFFFF, 32'h0,          16, 4'd0,  32'hFFFFFFC4,   4'd15, 32'h0,   32'hFFFFFFC0};
    tbl[4] = '{"ibw", 1'b1, 1'b1, 16'h8000, 32'hFFFFFFFC,   1,  4'd15, 32'h0,          4'd15, 32'h0,   32'h0};

    reset = 1'b1; start = 1'b0; up = 1'b0; pre = 1'b0; advance = 1'b0; list = '0; base = '0;
    #1;
    cycle();
    chk("reset_addr", addr, 0);
    cycle();
    reset = 1'b0;
    advance = 1'b1;
    cycle();

    for (int t = 0; t < 5; t++) run_vec(tbl[t]);

    // IB single register with advance held low for three cycles.
    start = 1'b1; up = 1'b1; pre = 1'b1; list = 16'h0010; base = 32'h40; advance = 1'b0;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("hold_idx", idx, 4);
      chk("hold_addr", addr, 32'h44);
      chk("hold_last", last, 1);
    end
    advance = 1'b1;
    cycle();
    chk("hold_done", done, 1);
    chk("hold_busy", busy, 0);
    cycle();
    chk("hold_done_once", done, 0);

    // Reset during the second transfer of an IA block, then restart.
    start = 1'b1; up = 1'b1; pre = 1'b0; list = 16'h00F0; base = 32'h1000; advance = 1'b1;
    cycle();
    start = 1'b0;
    chk("abort_first_idx", idx, 4);
    cycle();
    chk("abort_second_idx", idx, 5);
    reset = 1'b1;
    cycle();
    chk("abort_busy", busy, 0);
    chk("abort_valid", valid, 0);
    reset = 1'b0;
    cycle();
    chk("abort_no_done", done, 0);
    run_vec(tbl[0]);

    // Randomised traffic against the queue model.
    for (int c = 0; c < 2000; c++) begin
      reset   = ($urandom_range(0, 59) == 0);
      start   = ($urandom_range(0, 2) == 0);
      up      = $urandom_range(0, 1);
      pre     = $urandom_range(0, 1);
      advance = ($urandom_range(0, 9) < 7);
      base    = $urandom;
      case ($urandom_range(0, 3))
        0:       list = '0;
        1:       list = 16'(1) << $urandom_range(0, NREGS - 1);
        default: list = 16'($urandom);
      endcase
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
